// File: rtl/fifo_flagged.sv
// Single-clock FIFO with occupancy count, programmable almost flags,
// sticky overflow/underflow error flags and a registered or
// first-word-fall-through read port.
module fifo_flagged #(
  parameter int DataWidth      = 32,
  parameter int Depth          = 16,
  parameter int PtrWidth       = $clog2(Depth),
  parameter int AlmostFullThr  = 12,
  parameter int AlmostEmptyThr = 2,
  parameter int Fwft           = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 writeEn,
  input  logic [DataWidth-1:0] writeData,
  input  logic                 readEn,
  output logic [DataWidth-1:0] readData,
  output logic                 readValid,
  output logic                 full,
  output logic                 empty,
  output logic                 almostFull,
  output logic                 almostEmpty,
  output logic [PtrWidth:0]    count,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 clrErr
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PtrWidth:0]    wr_ptr, rd_ptr;
  logic [DataWidth-1:0] mem [Depth];
  logic                 wr_acc, rd_acc;

  // Acceptance uses pre-edge flags only: no bypass when full or empty.
  assign wr_acc      = writeEn & ~full;
  assign rd_acc      = readEn & ~empty;

  assign count       = wr_ptr - rd_ptr;
  assign full        = (count == (PtrWidth+1)'(Depth));
  assign empty       = (count == '0);
  assign almostFull  = (count >= (PtrWidth+1)'(AlmostFullThr));
  assign almostEmpty = (count <= (PtrWidth+1)'(AlmostEmptyThr));

  // Pointer advance on accepted requests; reset discards all entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; contents intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[PtrWidth-1:0]] <= writeData;
  end

  // Sticky error flags; a new error in the clear cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (writeEn & full)  | (overflow  & ~clrErr);
      underflow <= (readEn  & empty) | (underflow & ~clrErr);
    end
  end

  generate
    if (Fwft == 0) begin : g_reg
      logic [DataWidth-1:0] rd_data_q;
      logic                 rd_valid_q;

      // Registered read: data lands the edge after acceptance, valid for one cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= mem[rd_ptr[PtrWidth-1:0]];
        end
      end

      assign readData  = rd_data_q;
      assign readValid = rd_valid_q;
    end else begin : g_fwft
      // Head word is presented directly; readEn acknowledges it.
      assign readData  = mem[rd_ptr[PtrWidth-1:0]];
      assign readValid = ~empty;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_flagged.sv
// Bench for fifo_flagged: a registered-read and a FWFT instance share one
// stimulus stream and are compared every cycle against a queue-based model.
module tb_fifo_flagged;
  localparam int DW = 32;
  localparam int D  = 16;
  localparam int PW = $clog2(D);

  logic          clk, rst_n;
  logic          writeEn, readEn, clrErr;
  logic [DW-1:0] writeData;

  logic [DW-1:0] rd0, rd1;
  logic          rv0, rv1, full0, full1, empty0, empty1;
  logic          af0, af1, ae0, ae1, ovf0, ovf1, unf0, unf1;
  logic [PW:0]   cnt0, cnt1;

  fifo_flagged #(.DataWidth(DW), .Depth(D), .AlmostFullThr(12), .AlmostEmptyThr(2), .Fwft(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .writeEn(writeEn), .writeData(writeData), .readEn(readEn),
    .readData(rd0), .readValid(rv0), .full(full0), .empty(empty0), .almostFull(af0),
    .almostEmpty(ae0), .count(cnt0), .overflow(ovf0), .underflow(unf0), .clrErr(clrErr));

  fifo_flagged #(.DataWidth(DW), .Depth(D), .AlmostFullThr(12), .AlmostEmptyThr(2), .Fwft(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .writeEn(writeEn), .writeData(writeData), .readEn(readEn),
    .readData(rd1), .readValid(rv1), .full(full1), .empty(empty1), .almostFull(af1),
    .almostEmpty(ae1), .count(cnt1), .overflow(ovf1), .underflow(unf1), .clrErr(clrErr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus sticky flags and the
  // last popped word (what the registered port must show).
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd;
  logic          m_rv, m_ovf, m_unf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_rd  = '0;
      m_rv  = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      bit was_full, was_empty;
      was_full  = (q.size() == D);
      was_empty = (q.size() == 0);
      m_ovf = (writeEn && was_full)  || (m_ovf && !clrErr);
      m_unf = (readEn  && was_empty) || (m_unf && !clrErr);
      m_rv  = readEn && !was_empty;
      if (readEn && !was_empty) m_rd = q.pop_front();
      if (writeEn && !was_full) q.push_back(writeData);
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    int n;
    n = q.size();
    chk("count0", 64'(cnt0), 64'(n));
    chk("count1", 64'(cnt1), 64'(n));
    chk("full",   {62'd0, full0, full1},   {62'd0, n == D, n == D});
    chk("empty",  {62'd0, empty0, empty1}, {62'd0, n == 0, n == 0});
    chk("afull",  {62'd0, af0, af1},       {62'd0, n >= 12, n >= 12});
    chk("aempty", {62'd0, ae0, ae1},       {62'd0, n <= 2, n <= 2});
    chk("ovf",    {62'd0, ovf0, ovf1},     {62'd0, m_ovf, m_ovf});
    chk("unf",    {62'd0, unf0, unf1},     {62'd0, m_unf, m_unf});
    chk("rvalid0", 64'(rv0), 64'(m_rv));
    chk("rdata0",  64'(rd0), 64'(m_rd));
    chk("rvalid1", 64'(rv1), 64'(n != 0));
    if (n != 0) chk("rdata1", 64'(rd1), 64'(q[0]));
  end

  // One clock of stimulus; returns at the following falling edge.
  task automatic step(input logic we, input logic [DW-1:0] wd, input logic re, input logic clr);
    writeEn = we; writeData = wd; readEn = re; clrErr = clr;
    @(posedge clk);
    @(negedge clk);
    writeEn = 1'b0; readEn = 1'b0; clrErr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; writeEn = 1'b0; readEn = 1'b0; clrErr = 1'b0; writeData = '0;
    #12 rst_n = 1'b1;
    @(negedge clk);
    // Reset values pinned literally.
    chk("rst_count", 64'(cnt0), 64'd0);
    chk("rst_flags", {58'd0, empty0, full0, ae0, af0, ovf0, unf0}, {58'd0, 6'b101000});
    chk("rst_rv0", 64'(rv0), 64'd0);

    // Fill 0..15, then one write too many.
    for (int i = 0; i < D; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0);
      if (i == 11) chk("af_at12", 64'(af0), 64'd1);
      if (i == 10) chk("af_at11", 64'(af0), 64'd0);
    end
    chk("fill_count", 64'(cnt0), 64'd16);
    chk("fill_full",  64'(full0), 64'd1);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("ovf_count", 64'(cnt0), 64'd16);
    chk("ovf_set",   64'(ovf0), 64'd1);
    chk("ovf_head",  64'(rd1), 64'd0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("ovf_sticky", 64'(ovf0), 64'd1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("ovf_clr", 64'(ovf0), 64'd0);

    // Drain: data 0..15 one cycle after each accepted read.
    for (int i = 0; i < D; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      if (i == 0 || i == 15) chk("drain_data", {31'd0, rv0, rd0}, {31'd0, 1'b1, DW'(i)});
    end
    step(1'b0, '0, 1'b0, 1'b0);
    chk("drain_rv_drop", 64'(rv0), 64'd0);

    // Read+write while empty: write lands, read rejected.
    step(1'b1, 32'h1111_2222, 1'b1, 1'b0);
    chk("unf_set",   64'(unf0), 64'd1);
    chk("unf_count", 64'(cnt0), 64'd1);
    chk("unf_rv0",   64'(rv0), 64'd0);
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 32'h100 + DW'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h200 + DW'(i), 1'b1, 1'b0);
      chk("rw_count8", 64'(cnt0), 64'd8);
    end

    // Random traffic around half occupancy; pointers wrap several times.
    for (int i = 0; i < 300; i++) begin
      int n;
      logic we, re;
      n  = q.size();
      we = ($urandom_range(0, 15) < (n < 8 ? 12 : 6));
      re = ($urandom_range(0, 15) < (n > 8 ? 12 : 6));
      if (i % 50 == 49) begin
        we = 1'b1; re = 1'b1;
      end
      step(we, $urandom, re, ($urandom_range(0, 19) == 0));
    end
    // Push to the edges so almost flags and errors exercise both ends.
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, $urandom, $urandom_range(0, 3) == 0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, $urandom, 1'b1, 1'b0);

    // Asynchronous reset mid-traffic.
    writeEn = 1'b1; writeData = 32'h5555_AAAA;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 64'(cnt0), 64'd0);
    chk("arst_flags", {58'd0, empty0, full0, ae0, af0, ovf0, unf0}, {58'd0, 6'b101000});
    chk("arst_rd0", {31'd0, rv0, rd0}, 64'd0);
    chk("arst_rv1", 64'(rv1), 64'd0);
    writeEn = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("post_rst_empty", {62'd0, rv0, unf0}, {62'd0, 1'b0, 1'b1});

    // First-word-fall-through presentation.
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
    chk("fwft_head", {31'd0, rv1, rd1}, {31'd0, 1'b1, 32'hA5A5_A5A5});
    step(1'b0, '0, 1'b1, 1'b0);
    chk("fwft_pop", {62'd0, empty1, rv1}, {62'd0, 1'b1, 1'b0});
    chk("fwft_reg_port", {31'd0, rv0, rd0}, {31'd0, 1'b1, 32'hA5A5_A5A5});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
